alu_cmd_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver and assembles 5-byte command frames
//  {HEADER, OPCODE, OPERAND_A, OPERAND_B, CHECKSUM}.
//  On a checksum-valid frame it presents opcode and operands to the ALU with a 1-cycle

---
 rtl/alu_cmd_parser.sv | 83 ++++++++
 tb/tb_alu_cmd_parser.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_parser.sv
// Assembles 5-byte {HEADER, OP, A, B, CHK} frames from the UART byte stream and
// hands checksum-valid commands to the ALU; bad or stalled frames are dropped and flagged.
module alu_cmd_parser #(
  parameter logic [7:0] HEADER         = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_a,
  output logic [7:0] cmd_b,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_OP, GET_A, GET_B, GET_CHK} state_t;

  state_t        r_state;
  logic [7:0]    r_op, r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;

  // A byte arriving in the timeout cycle wins, so rx_valid masks the expiry.
  assign w_timeout = (r_state != IDLE) && !rx_valid && (r_cnt == TO_LAST);
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      cmd_op    <= '0;
      cmd_a     <= '0;
      cmd_b     <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (rx_valid && rx_data == HEADER) r_state <= GET_OP;
      end else if (rx_valid) begin
        r_cnt <= '0;
        case (r_state)
          GET_OP: begin r_op <= rx_data; r_state <= GET_A; end
          GET_A:  begin r_a  <= rx_data; r_state <= GET_B; end
          GET_B:  begin r_b  <= rx_data; r_state <= GET_CHK; end
          default: begin
            r_state <= IDLE;
            if (rx_data == (r_op ^ r_a ^ r_b)) begin
              cmd_op    <= r_op;
              cmd_a     <= r_a;
              cmd_b     <= r_b;
              cmd_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        frame_err <= 1'b1;
        err_code  <= 2'b10;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Directed bench for alu_cmd_parser: good/bad frames, timeout edge, header-valued
// payload, garbage before header, back-to-back frames and async reset mid-frame.
module tb_alu_cmd_parser;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] cmd_op, cmd_a, cmd_b;
  logic       cmd_valid, frame_err, busy;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int n_cv   = 0;
  int n_fe   = 0;
  int cv0, fe0;

  alu_cmd_parser #(.HEADER(8'hAA), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sample pre-edge values, so they are stable at the negedge.
  always @(posedge clk) begin
    n_cv <= n_cv + int'(cmd_valid);
    n_fe <= n_fe + int'(frame_err);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is taken on the following posedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    cv0 = n_cv;
    fe0 = n_fe;
  endtask

  initial begin
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    idle(2);
    chk("rst_op",   cmd_op, 0);
    chk("rst_cv",   cmd_valid, 0);
    chk("rst_fe",   frame_err, 0);
    chk("rst_ec",   err_code, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    idle(2);

    // 1: good frame, pulse one cycle after checksum strobe
    snap();
    send(8'hAA); send(8'h01); send(8'h05);
    chk("t1_busy_mid", busy, 1);
    send(8'h03);
    chk("t1_cv_early", cmd_valid, 0);
    send(8'h07);
    chk("t1_cv",   cmd_valid, 1);
    chk("t1_cmd",  {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00010503);
    chk("t1_busy", busy, 0);
    idle(1);
    chk("t1_cv_off", cmd_valid, 0);
    idle(2);
    chk("t1_ncv", n_cv - cv0, 1);
    chk("t1_nfe", n_fe - fe0, 0);

    // 2: bad checksum
    snap();
    send(8'hAA); send(8'h01); send(8'h05); send(8'h03); send(8'h08);
    chk("t2_fe",  frame_err, 1);
    chk("t2_ec",  err_code, 2'b01);
    chk("t2_cv",  cmd_valid, 0);
    chk("t2_cmd", {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00010503);
    idle(1);
    chk("t2_fe_off", frame_err, 0);
    chk("t2_ec_hold", err_code, 2'b01);
    idle(2);
    chk("t2_ncv", n_cv - cv0, 0);
    chk("t2_nfe", n_fe - fe0, 1);

    // 3: timeout exactly T clocks after the last strobe
    send(8'hAA); send(8'h02);
    idle(T - 1);
    chk("t3_fe_early", frame_err, 0);
    chk("t3_busy_pre", busy, 1);
    idle(1);
    chk("t3_fe",   frame_err, 1);
    chk("t3_ec",   err_code, 2'b10);
    chk("t3_busy", busy, 0);
    idle(1);
    snap();
    send(8'hAA); send(8'h02); send(8'h0A); send(8'h04); send(8'h0C);
    chk("t3_cv",  cmd_valid, 1);
    chk("t3_cmd", {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00020A04);
    idle(2);
    chk("t3_nfe", n_fe - fe0, 0);

    // byte arriving in the timeout cycle is accepted, no error
    snap();
    send(8'hAA); send(8'h02);
    idle(T - 1);
    send(8'h0B);
    chk("tw_busy", busy, 1);
    chk("tw_fe",   frame_err, 0);
    send(8'h04); send(8'h0D);
    chk("tw_cv",  cmd_valid, 1);
    chk("tw_cmd", {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00020B04);
    idle(2);
    chk("tw_nfe", n_fe - fe0, 0);

    // 4: garbage before header, then back-to-back next frame
    snap();
    send(8'h55); send(8'h12);
    chk("t4_busy_garbage", busy, 0);
    send(8'hAA); send(8'h03); send(8'h10); send(8'h20); send(8'h33);
    chk("t4_cv",  cmd_valid, 1);
    chk("t4_cmd", {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00031020);
    send(8'hAA); send(8'h04); send(8'h01); send(8'h02); send(8'h07);
    chk("bb_cmd", {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00040102);
    idle(2);
    chk("t4_ncv", n_cv - cv0, 2);
    chk("t4_nfe", n_fe - fe0, 0);

    // 5: header-valued payload
    snap();
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'hAA); send(8'hAA);
    chk("t5_cv",  cmd_valid, 1);
    chk("t5_cmd", {8'h0, cmd_op, cmd_a, cmd_b}, 32'h00AAAAAA);
    idle(2);
    chk("t5_ncv", n_cv - cv0, 1);
    chk("t5_nfe", n_fe - fe0, 0);

    // 6: async reset mid-frame
    send(8'hAA); send(8'h01); send(8'h05);
    #2 rst = 1'b0;
    #1;
    chk("t6_cmd",  {8'h0, cmd_op, cmd_a, cmd_b}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ec",   err_code, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    snap();
    send(8'h05); send(8'h03); send(8'h07);
    idle(3);
    chk("t6_ncv", n_cv - cv0, 0);
    chk("t6_nfe", n_fe - fe0, 0);
    chk("t6_cmd_after", {8'h0, cmd_op, cmd_a, cmd_b}, 0);
    chk("t6_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
